// File: rtl/wb_slv_pkg.sv
// Shared helpers for the Wishbone slave: lane/shift math, the termination
// kind, a maximum-width byte-select type and the address window check.
package wb_slv_pkg;

  localparam int MAX_LANES = 8;

  typedef logic [MAX_LANES-1:0] sel_max_t;

  typedef enum logic [1:0] {
    TERM_NONE,
    TERM_ACK,
    TERM_ERR
  } term_t;

  // Number of byte lanes on a bus of the given width.
  function automatic int lane_count(input int bus_width);
    return bus_width / 8;
  endfunction

  // Right shift that turns a byte offset into a word index.
  function automatic int addr_shift(input int bus_width);
    return $clog2(bus_width / 8);
  endfunction

  // True when adr falls inside [base, base + depth*bytes_per_word).
  // The span is computed in 64 bits so a window ending at 2^32 cannot wrap.
  function automatic logic in_range(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input int          depth,
                                    input int          bus_width);
    logic [63:0] span;
    logic [31:0] off;
    span = 64'(depth) * 64'(bus_width / 8);
    off  = adr - base;
    return (adr >= base) && (64'(off) < span);
  endfunction

endpackage

// File: rtl/wb_modport_slave_if.sv
// Wishbone classic bus bundle with master and slave views.
interface wb_modport_slave_if #(
  parameter int BUS_WIDTH = 32
);
  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [31:0]            adr;
  logic [BUS_WIDTH/8-1:0] sel;
  logic [BUS_WIDTH-1:0]   datSlvIn;
  logic [BUS_WIDTH-1:0]   datMstIn;
  logic                   ack;
  logic                   err;

  modport master (
    output cyc, stb, we, adr, sel, datSlvIn,
    input  datMstIn, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, datSlvIn,
    output datMstIn, ack, err
  );
endinterface

// File: rtl/wb_slv_ram.sv
// Single-port synchronous RAM, one byte-wide array per lane so each lane has
// its own write enable; read data is registered and only updates on rd_en.
module wb_slv_ram
  import wb_slv_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 256
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [lane_count(BUS_WIDTH)-1:0] be,
  input  logic [$clog2(DEPTH)-1:0]       addr,
  input  logic [BUS_WIDTH-1:0]           wdata,
  output logic [BUS_WIDTH-1:0]           rdata
);
  localparam int LANES = lane_count(BUS_WIDTH);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rdata_lane_reg;

      // Per-lane byte write and registered read of the addressed word.
      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rdata_lane_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = rdata_lane_reg;
    end
  endgenerate

endmodule

// File: rtl/wb_modport_slave.sv
// Wishbone classic single-beat slave in front of a byte-enabled RAM.
// Fixed one-cycle ack/err termination; a held request is served every other
// cycle because the pending termination masks the next request.
// Optional macro WB_SLV_ERR_EN: out-of-range or sel==0 requests end in err;
// without it err is tied low and out-of-range reads return zero.
module wb_modport_slave
  import wb_slv_pkg::*;
#(
  parameter int          BUS_WIDTH = 32,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  wb_modport_slave_if.slave  bus
);
  localparam int SHIFT = addr_shift(BUS_WIDTH);
  localparam int AW    = $clog2(DEPTH);

  logic                 req;
  logic                 hit;
  logic                 ram_wr;
  logic                 ram_rd;
  logic                 ack_reg;
  logic                 err_reg;
  logic                 rd_zero_reg;
  logic [AW-1:0]        idx;
  logic [BUS_WIDTH-1:0] ram_rdata;
  term_t                term_next;

  assign req = bus.cyc & bus.stb & ~ack_reg & ~err_reg;
  assign hit = in_range(bus.adr, BASE_ADDR, DEPTH, BUS_WIDTH);
  assign idx = AW'((bus.adr - BASE_ADDR) >> SHIFT);

  // Decode the request into a termination kind and RAM strobes; reset
  // suppresses every RAM access sampled on its edge.
  always_comb begin
    term_next = TERM_NONE;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    if (req) begin
`ifdef WB_SLV_ERR_EN
      if (!hit || sel_max_t'(bus.sel) == '0) begin
        term_next = TERM_ERR;
      end else begin
        term_next = TERM_ACK;
        ram_wr    = bus.we;
        ram_rd    = ~bus.we;
      end
`else
      term_next = TERM_ACK;
      ram_wr    = bus.we & hit;
      ram_rd    = ~bus.we & hit;
`endif
    end
    if (rst) begin
      ram_wr = 1'b0;
      ram_rd = 1'b0;
    end
  end

  // Termination flops plus the flag that forces read data to zero after
  // reset or after an out-of-range read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      rd_zero_reg <= 1'b1;
    end else begin
      ack_reg <= (term_next == TERM_ACK);
      err_reg <= (term_next == TERM_ERR);
      if (ram_rd) begin
        rd_zero_reg <= 1'b0;
      end
`ifndef WB_SLV_ERR_EN
      else if (req && !bus.we && !hit) begin
        rd_zero_reg <= 1'b1;
      end
`endif
    end
  end

  wb_slv_ram #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wr_en (ram_wr),
    .rd_en (ram_rd),
    .be    (bus.sel),
    .addr  (idx),
    .wdata (bus.datSlvIn),
    .rdata (ram_rdata)
  );

  assign bus.ack      = ack_reg;
  assign bus.datMstIn = rd_zero_reg ? '0 : ram_rdata;
`ifdef WB_SLV_ERR_EN
  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_modport_slave.sv
// Directed bench for wb_modport_slave: the driver pushes the expected
// termination (kind, cycle, read data) into a queue; a monitor on the falling
// edge pops and compares every ack/err the slave presents.
module tb_wb_modport_slave;
  import wb_slv_pkg::*;

  localparam int          BW    = 32;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cnt = 0;
  int   total = 0;
  int   bad = 0;
  bit   prev_term = 1'b0;
  exp_t sbq[$];

  wb_modport_slave_if #(.BUS_WIDTH(BW)) bus ();

  wb_modport_slave #(
    .BUS_WIDTH (BW),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cnt);
    end
  endfunction

  // Monitor: every termination must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack === 1'b1 || bus.err === 1'b1) begin
      $display("term cycle=%0d ack=%b err=%b dat=%h", cnt, bus.ack, bus.err,
               bus.datMstIn);
      chk("term_width", 64'(prev_term), 64'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_term", 64'({bus.ack, bus.err}), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("term_kind", 64'({bus.ack, bus.err}), e.is_err ? 64'd1 : 64'd2);
        chk("term_cycle", 64'(cnt), 64'(e.cnt));
        if (e.chk_data) chk("rdata", 64'(bus.datMstIn), 64'(e.data));
      end
      prev_term = 1'b1;
    end else begin
      prev_term = 1'b0;
    end
  end

  task automatic push(input bit is_err, input bit chk_d,
                      input logic [31:0] d, input int at);
    exp_t e;
    e.is_err   = is_err;
    e.chk_data = chk_d;
    e.data     = d;
    e.cnt      = at;
    sbq.push_back(e);
  endtask

  // One single-beat transfer; called right after a falling edge.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit exp_err,
                      input bit chk_d, input logic [31:0] exp_d);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w;
    bus.adr = a; bus.sel = s; bus.datSlvIn = d;
    push(exp_err, chk_d, exp_d, cnt + 1);
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d);
    xfer(1'b1, a, s, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expd);
    xfer(1'b0, a, 4'hF, 32'h0, 1'b0, 1'b1, expd);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.adr = BASE; bus.sel = 4'hF; bus.datSlvIn = '0;

    // Reset held 3 cycles with a live request: nothing may terminate.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", 64'(bus.ack), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_dat", 64'(bus.datMstIn), 64'd0);
    end
    // First termination lands one cycle after rst falls.
    rst = 1'b0;
    xfer(1'b1, BASE, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);

    // Full write then read.
    wr(BASE + 32'd8, 4'hF, 32'hDEADBEEF);
    rd(BASE + 32'd8, 32'hDEADBEEF);

    // Byte-lane merge on word 6.
    wr(BASE + 32'd24, 4'hF, 32'h11223344);
    wr(BASE + 32'd24, 4'b0101, 32'hAABBCCDD);
    rd(BASE + 32'd24, 32'h11BB33DD);

    // Preload words 0..3 and word 5.
    for (int i = 0; i < 4; i++) wr(BASE + 32'(4 * i), 4'hF, 32'(i));
    wr(BASE + 32'd20, 4'hF, 32'h0);

    // Back-to-back reads with cyc/stb held: one ack every other cycle.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
    c0 = cnt;
    for (int i = 0; i < 4; i++) begin
      bus.adr = BASE + 32'(4 * i);
      push(1'b0, 1'b1, 32'(i), c0 + 1 + 2 * i);
      @(negedge clk);
      @(negedge clk);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clk);

    // sel = 0 write to word 2 leaves it untouched.
`ifdef WB_SLV_ERR_EN
    xfer(1'b1, BASE + 32'd8, 4'h0, 32'h12345678, 1'b1, 1'b0, 32'h0);
`else
    xfer(1'b1, BASE + 32'd8, 4'h0, 32'h12345678, 1'b0, 1'b0, 32'h0);
`endif
    rd(BASE + 32'd8, 32'h2);

    // Out of range just past the top; index would alias to word 0.
`ifdef WB_SLV_ERR_EN
    xfer(1'b0, BASE + 32'(DEPTH * 4), 4'hF, 32'h0, 1'b1, 1'b1, 32'h2);
    xfer(1'b1, BASE + 32'(DEPTH * 4), 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
`else
    xfer(1'b0, BASE + 32'(DEPTH * 4), 4'hF, 32'h0, 1'b0, 1'b1, 32'h0);
    xfer(1'b1, BASE + 32'(DEPTH * 4), 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
`endif
    rd(BASE, 32'h0);
    rd(BASE + 32'd4, 32'h1);

    // Reset on the same edge as a write to word 5: discarded, no ack.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = BASE + 32'd20; bus.sel = 4'hF; bus.datSlvIn = 32'hCAFEF00D;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ack", 64'(bus.ack), 64'd0);
    chk("rstw_dat", 64'(bus.datMstIn), 64'd0);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rd(BASE + 32'd20, 32'h0);

    repeat (3) @(negedge clk);
    chk("pending", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got cycle %0d expected finish", cnt);
    $fatal(1, "timeout");
  end

endmodule
